instr_encoder: RTL and testbench

Sequential instruction encoder and loader for the single-cycle MIPS core: the inverse of the control decoder. It accepts symbolic instructions (operation select plus register, immediate and target fields) over a valid/ready stream. It packs each one into a 32-bit MIPS word using the core's opcode map, then writes the words to consecutive instruction-memory addresses. Test harnesses and the boot path use it to populate instruction memory before releasing the core.

---
 rtl/instr_encoder.sv | 159 +++++++++++++++
 tb/tb_instr_encoder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic MIPS instructions into 32-bit words and
// streams them into consecutive instruction-memory addresses.
module instr_encoder #(
    parameter int DEPTH = 256,
    parameter int CNT_W = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      base_addr_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             in_last_i,
    input  logic [3:0]       op_sel_i,
    input  logic [4:0]       rs_i,
    input  logic [4:0]       rt_i,
    input  logic [4:0]       rd_i,
    input  logic [4:0]       shamt_i,
    input  logic [5:0]       funct_i,
    input  logic [15:0]      imm_i,
    input  logic [25:0]      target_i,
    output logic             im_we_o,
    output logic [31:0]      im_addr_o,
    output logic [31:0]      im_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] count_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W:0] ONE_C   = (CNT_W + 1)'(1);

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_ptr;
    logic [31:0]      r_addr;
    logic [31:0]      r_data;
    logic [CNT_W-1:0] r_count;
    logic             r_we;
    logic             r_err;
    logic [CNT_W:0]   w_used;
    logic             w_hs;
    logic             w_legal;
    logic             w_full;
    logic [31:0]      w_word;

    // Opcode map and field placement; BNEZ/BGEZ/LUI override one register field.
    function automatic logic [31:0] f_encode(
        input logic [3:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [5:0]  funct,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] word;
        word = 32'd0;
        case (op)
            4'd0:    word = {6'b000000, rs, rt, rd, shamt, funct};
            4'd1:    word = {6'b001000, rs, rt, imm};
            4'd2:    word = {6'b000100, rs, rt, imm};
            4'd3:    word = {6'b001101, rs, rt, imm};
            4'd4:    word = {6'b100011, rs, rt, imm};
            4'd5:    word = {6'b101011, rs, rt, imm};
            4'd6:    word = {6'b000010, target};
            4'd7:    word = {6'b000111, rs, rt, imm};
            4'd8:    word = {6'b000101, rs, 5'b00000, imm};
            4'd9:    word = {6'b000001, rs, 5'b00001, imm};
            4'd10:   word = {6'b001111, 5'b00000, rt, imm};
            4'd11:   word = {6'b000011, target};
            default: word = 32'd0;
        endcase
        return word;
    endfunction

    // A word sitting in the output register is not yet in r_count, so it is
    // added here to keep the capacity check exact at full throughput.
    assign w_used     = {1'b0, r_count} + {{CNT_W{1'b0}}, r_we};
    assign in_ready_o = (r_state == S_LOAD) && (w_used < DEPTH_C);
    assign w_hs       = in_valid_i && in_ready_o;
    assign w_legal    = (op_sel_i < 4'd12);
    assign w_full     = w_legal && ((w_used + ONE_C) >= DEPTH_C);
    assign w_word     = f_encode(op_sel_i, rs_i, rt_i, rd_i, shamt_i,
                                 funct_i, imm_i, target_i);

    assign im_we_o   = r_we;
    assign im_addr_o = r_addr;
    assign im_data_o = r_data;
    assign busy_o    = (r_state != S_IDLE);
    assign done_o    = (r_state == S_DONE);
    assign err_o     = r_err;
    assign count_o   = r_count;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: a session ends on an accepted last or on reaching capacity.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_next = S_LOAD;
            S_LOAD:  if (w_hs && (in_last_i || w_full)) w_next = S_FLUSH;
            S_FLUSH: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: latch the encoded word on handshake, count it once written.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr   <= 32'd0;
            r_addr  <= 32'd0;
            r_data  <= 32'd0;
            r_count <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_we <= w_hs && w_legal;
            if (r_we) begin
                r_count <= r_count + CNT_W'(1);
            end
            if ((r_state == S_IDLE) && start_i) begin
                r_ptr   <= base_addr_i & ~32'h3;
                r_count <= '0;
                r_err   <= 1'b0;
            end
            if (w_hs) begin
                if (w_legal) begin
                    r_addr <= r_ptr;
                    r_data <= w_word;
                    r_ptr  <= r_ptr + 32'd4;
                    if (!in_last_i && w_full) begin
                        r_err <= 1'b1;
                    end
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder (DEPTH=4 to reach the capacity limit).
module tb_instr_encoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] tgt;
    } instr_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } exp_t;

    localparam logic [5:0] OPC [12] = '{6'h00, 6'h08, 6'h04, 6'h0D, 6'h23, 6'h2B,
                                        6'h02, 6'h07, 6'h05, 6'h01, 6'h0F, 6'h03};

    logic             clk = 1'b0;
    logic             rst_i, start_i, in_valid_i, in_last_i;
    logic [31:0]      base_addr_i;
    logic [3:0]       op_sel_i;
    logic [4:0]       rs_i, rt_i, rd_i, shamt_i;
    logic [5:0]       funct_i;
    logic [15:0]      imm_i;
    logic [25:0]      target_i;
    logic             in_ready_o, im_we_o, busy_o, done_o, err_o;
    logic [31:0]      im_addr_o, im_data_o;
    logic [CNT_W-1:0] count_o;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          no_bubble = 1'b1;
    exp_t        exp_q[$];
    instr_t      sess[$];
    logic [31:0] log_a[$];
    logic [31:0] log_d[$];

    instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_last_i(in_last_i),
        .op_sel_i(op_sel_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .shamt_i(shamt_i),
        .funct_i(funct_i), .imm_i(imm_i), .target_i(target_i),
        .im_we_o(im_we_o), .im_addr_o(im_addr_o), .im_data_o(im_data_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Reference encoding: opcode table plus field shifts, overrides applied first.
    function automatic logic [31:0] model_word(input instr_t t);
        logic [4:0] rs;
        logic [4:0] rt;
        logic [31:0] op_f;
        rs = t.rs;
        rt = t.rt;
        if (t.op == 4'd8) rt = 5'd0;
        if (t.op == 4'd9) rt = 5'd1;
        if (t.op == 4'd10) rs = 5'd0;
        op_f = 32'(OPC[t.op]) << 26;
        if (t.op == 4'd0)
            return op_f | (32'(rs) << 21) | (32'(rt) << 16) | (32'(t.rd) << 11)
                        | (32'(t.sh) << 6) | 32'(t.fn);
        if (t.op == 4'd6 || t.op == 4'd11)
            return op_f | 32'(t.tgt);
        return op_f | (32'(rs) << 21) | (32'(rt) << 16) | 32'(t.imm);
    endfunction

    function automatic instr_t mk(input int op, input int rs, input int rt, input int rd,
                                  input int fn, input int imm, input int tgt);
        instr_t t;
        t.op = 4'(op); t.rs = 5'(rs); t.rt = 5'(rt); t.rd = 5'(rd); t.sh = 5'd0;
        t.fn = 6'(fn); t.imm = 16'(imm); t.tgt = 26'(tgt);
        return t;
    endfunction

    function automatic instr_t rnd_instr(input bit legal_only);
        instr_t t;
        t = instr_t'({$urandom, $urandom, $urandom});
        if (legal_only || $urandom_range(0, 4) != 0) t.op = 4'($urandom_range(0, 11));
        else t.op = 4'($urandom_range(12, 15));
        return t;
    endfunction

    // Monitor: every write must match the head of the scoreboard, in the right cycle.
    always @(negedge clk) begin
        exp_t e;
        if (im_we_o === 1'b1) begin
            log_a.push_back(im_addr_o);
            log_d.push_back(im_data_o);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write addr=0x%08h data=0x%08h", im_addr_o, im_data_o);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", im_addr_o, e.a);
                chk("write_data", im_data_o, e.d);
                chk("write_cycle", 32'(cyc), 32'(e.c));
            end
        end
    end

    task automatic drive(input instr_t t, input bit last);
        op_sel_i = t.op; rs_i = t.rs; rt_i = t.rt; rd_i = t.rd; shamt_i = t.sh;
        funct_i = t.fn; imm_i = t.imm; target_i = t.tgt;
        in_last_i = last; in_valid_i = 1'b1;
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_ready"}, 32'(in_ready_o), 0);
        chk({p, "_we"}, 32'(im_we_o), 0);
        chk({p, "_addr"}, im_addr_o, 0);
        chk({p, "_data"}, im_data_o, 0);
        chk({p, "_busy"}, 32'(busy_o), 0);
        chk({p, "_done"}, 32'(done_o), 0);
        chk({p, "_err"}, 32'(err_o), 0);
        chk({p, "_count"}, 32'(count_o), 0);
    endtask

    task automatic chk_log(input string nm, input int idx, input logic [31:0] a,
                           input logic [31:0] d);
        if (idx < log_a.size()) begin
            chk({nm, "_addr"}, log_a[idx], a);
            chk({nm, "_data"}, log_d[idx], d);
        end else begin
            chk({nm, "_present"}, 32'(log_a.size()), 32'(idx + 1));
        end
    endtask

    // Runs one load session over sess[]; the model decides acceptance, writes, err.
    task automatic run_session(input logic [31:0] base, input bit mark_last);
        int          n;
        int          legal;
        bit          err_m;
        bit          closed;
        logic [31:0] b;
        exp_t        e;
        n = sess.size(); legal = 0; err_m = 0; closed = 0;
        b = base & 32'hFFFF_FFFC;
        log_a.delete(); log_d.delete();
        @(posedge clk); #1;
        start_i = 1'b1;
        base_addr_i = base;
        if (n > 0) drive(sess[0], mark_last && n == 1);
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("start_busy", 32'(busy_o), 1);
        chk("start_count", 32'(count_o), 0);
        chk("start_err", 32'(err_o), 0);
        for (int i = 0; i < n && !closed; i++) begin
            drive(sess[i], mark_last && (i == n - 1));
            chk("ready_open", 32'(in_ready_o), 1);
            @(posedge clk); #1;
            if (sess[i].op < 4'd12) begin
                e.a = b + 32'(legal) * 32'd4;
                e.d = model_word(sess[i]);
                e.c = cyc;
                exp_q.push_back(e);
                legal++;
            end else begin
                err_m = 1'b1;
            end
            if (mark_last && i == n - 1) closed = 1'b1;
            else if (legal == DEPTH) begin
                closed = 1'b1;
                err_m = 1'b1;
            end
            if (closed) begin
                in_valid_i = 1'b0;
                chk("ready_closed", 32'(in_ready_o), 0);
            end else if (!no_bubble && $urandom_range(0, 3) == 0) begin
                in_valid_i = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid_i = 1'b0;
        in_last_i = 1'b0;
        chk("flush_done", 32'(done_o), 0);
        chk("flush_busy", 32'(busy_o), 1);
        @(posedge clk); #1;
        chk("done_pulse", 32'(done_o), 1);
        chk("done_busy", 32'(busy_o), 1);
        chk("done_count", 32'(count_o), 32'(legal));
        chk("done_err", 32'(err_o), 32'(err_m));
        @(posedge clk); #1;
        chk("idle_done", 32'(done_o), 0);
        chk("idle_busy", 32'(busy_o), 0);
        chk("idle_ready", 32'(in_ready_o), 0);
        chk("idle_err", 32'(err_o), 32'(err_m));
        chk("pending_writes", 32'(exp_q.size()), 0);
        if (log_a.size() > 0) begin
            chk("hold_addr", im_addr_o, log_a[log_a.size() - 1]);
            chk("hold_data", im_data_o, log_d[log_d.size() - 1]);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst_i = 1'b1; start_i = 1'b0; in_valid_i = 1'b0; in_last_i = 1'b0;
        base_addr_i = 32'd0; op_sel_i = 4'd0; rs_i = 5'd0; rt_i = 5'd0; rd_i = 5'd0;
        shamt_i = 5'd0; funct_i = 6'd0; imm_i = 16'd0; target_i = 26'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_i = 1'b0;

        // Single ADDI.
        sess = '{mk(1, 0, 8, 0, 0, 5, 0)};
        run_session(32'h0, 1'b1);
        chk("t1_writes", 32'(log_a.size()), 1);
        chk_log("t1_w0", 0, 32'h0, 32'h2008_0005);

        // R-type then J, back to back.
        sess = '{mk(0, 9, 10, 8, 6'h20, 0, 0), mk(6, 0, 0, 0, 0, 0, 26'h010_0000)};
        run_session(32'h100, 1'b1);
        chk_log("t2_w0", 0, 32'h100, 32'h012A_4020);
        chk_log("t2_w1", 1, 32'h104, 32'h0810_0000);

        // Field overrides on BGEZ and LUI.
        sess = '{mk(9, 4, 7, 0, 0, 3, 0), mk(10, 7, 1, 0, 0, 16'h1234, 0)};
        run_session(32'h200, 1'b1);
        chk_log("t3_w0", 0, 32'h200, 32'h0481_0003);
        chk_log("t3_w1", 1, 32'h204, 32'h3C01_1234);

        // Illegal op between two legal ones.
        sess = '{mk(1, 1, 2, 0, 0, 7, 0), mk(13, 3, 3, 3, 3, 3, 3), mk(3, 3, 4, 0, 0, 16'h00FF, 0)};
        run_session(32'h303, 1'b1);
        chk("t4_writes", 32'(log_a.size()), 2);
        chk_log("t4_w0", 0, 32'h300, 32'h2022_0007);
        chk_log("t4_w1", 1, 32'h304, 32'h3464_00FF);

        // Capacity overflow: six offered, none last.
        sess.delete();
        for (int i = 0; i < 6; i++) sess.push_back(mk(1, i, i + 1, 0, 0, i * 3, 0));
        run_session(32'h400, 1'b0);
        chk("t5_writes", 32'(log_a.size()), 4);

        // Reset in the middle of a session, after two writes.
        @(posedge clk); #1;
        start_i = 1'b1; base_addr_i = 32'h40;
        @(posedge clk); #1;
        start_i = 1'b0;
        sess = '{mk(4, 5, 6, 0, 0, 16'h0010, 0), mk(5, 7, 8, 0, 0, 16'h0020, 0)};
        for (int i = 0; i < 2; i++) begin
            drive(sess[i], 1'b0);
            @(posedge clk); #1;
            e.a = 32'h40 + 32'(i) * 32'd4;
            e.d = model_word(sess[i]);
            e.c = cyc;
            exp_q.push_back(e);
        end
        in_valid_i = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_count", 32'(count_o), 2);
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        chk_zero("midrst");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_done", 32'(done_o), 0);
        end
        chk("midrst_pending", 32'(exp_q.size()), 0);
        sess = '{mk(11, 0, 0, 0, 0, 0, 26'h3AB_CDEF)};
        run_session(32'h80, 1'b1);
        chk_log("t6_w0", 0, 32'h80, 32'h0FAB_CDEF);

        // Randomized sessions, including address wrap near 2^32.
        no_bubble = 1'b0;
        for (int s = 0; s < 40; s++) begin
            logic [31:0] base;
            bit overflow;
            base = $urandom;
            if ($urandom_range(0, 3) == 0) base = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            overflow = ($urandom_range(0, 4) == 0);
            sess.delete();
            if (overflow) begin
                for (int i = 0; i < 6; i++) sess.push_back(rnd_instr(1'b1));
            end else begin
                for (int i = 0; i < int'($urandom_range(1, 5)); i++) sess.push_back(rnd_instr(1'b0));
            end
            run_session(base, !overflow);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
